// File: rtl/fir_fixed_acc_43s_24s.sv
// FIR tap accumulator: sums NUM_TAPS signed 43-bit products, rounds half-up, rescales and emits a 24-bit sample.
// Optional macro FIR_ACC_SAT_EN: saturate the 24-bit sample and raise sticky ovf instead of wrapping.
module fir_fixed_acc_43s_24s #(
  parameter int NUM_TAPS   = 16,
  parameter int ACC_W      = 49,
  parameter int FRAC_SHIFT = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic signed [42:0] prod,
  input  logic               prod_vld,
  input  logic               prod_last,
  output logic               in_rdy,
  output logic signed [23:0] dout,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic               err_len,
  output logic               ovf,
  output logic [1:0]         dbg_state
);

  // Handshakes: a product transfers on a rising edge where ce & prod_vld & in_rdy;
  // a sample transfers on a rising edge where ce & out_vld & out_rdy. Once raised,
  // out_vld and dout stay stable until that transfer.

  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam logic signed [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]             count_q, count_d;
  logic signed [23:0]        dout_q, dout_d;
  logic                      out_vld_q, out_vld_d;
  logic                      in_rdy_q, in_rdy_d;
  logic                      err_len_q, err_len_d;

  logic                      accept;
  logic [CW-1:0]             count_inc;
  logic                      count_full;
  logic                      frame_end;
  logic                      len_bad;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     rnd_sum;
  logic signed [ACC_W:0]     r_full;
  logic signed [23:0]        sample;

  assign accept     = ce & prod_vld & in_rdy_q;
  assign count_inc  = count_q + CW'(1);
  assign count_full = (count_inc == CW'(NUM_TAPS));
  assign frame_end  = prod_last | count_full;
  assign len_bad    = prod_last ^ count_full;
  assign prod_ext   = {{(ACC_W-43){prod[42]}}, prod};

  // One extra bit so adding the rounding constant can never wrap the sum.
  assign rnd_sum = {acc_q[ACC_W-1], acc_q} + RND;
  assign r_full  = rnd_sum >>> FRAC_SHIFT;

`ifdef FIR_ACC_SAT_EN
  logic sat_hi, sat_lo;
  logic ovf_q, ovf_d;

  assign sat_hi = ~r_full[ACC_W] & (|r_full[ACC_W-1:23]);
  assign sat_lo = r_full[ACC_W] & ~(&r_full[ACC_W-1:23]);
  assign sample = sat_hi ? 24'sh7FFFFF : (sat_lo ? 24'sh800000 : r_full[23:0]);
  assign ovf    = ovf_q;
`else
  logic unused_r_hi;

  assign unused_r_hi = ^r_full[ACC_W:24];
  assign sample      = r_full[23:0];
  assign ovf         = 1'b0;
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      err_len_q <= 1'b0;
`ifdef FIR_ACC_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else if (ce) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      out_vld_q <= out_vld_d;
      in_rdy_q  <= in_rdy_d;
      err_len_q <= err_len_d;
`ifdef FIR_ACC_SAT_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) state_d = frame_end ? S_ROUND : S_ACCUM;
      end
      S_ROUND: state_d = S_HOLD;
      S_HOLD:  if (out_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    dout_d    = dout_q;
    out_vld_d = out_vld_q;
    err_len_d = err_len_q;
`ifdef FIR_ACC_SAT_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = prod_ext;
          count_d = CW'(1);
          if (len_bad) err_len_d = 1'b1;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_inc;
          if (len_bad) err_len_d = 1'b1;
        end
      end
      S_ROUND: begin
        dout_d    = sample;
        out_vld_d = 1'b1;
        acc_d     = '0;
        count_d   = '0;
`ifdef FIR_ACC_SAT_EN
        if (sat_hi | sat_lo) ovf_d = 1'b1;
`endif
      end
      S_HOLD: begin
        if (out_rdy) out_vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  // in_rdy is registered so it reads 0 throughout reset
  always_comb begin
    in_rdy_d = (state_d == S_IDLE) || (state_d == S_ACCUM);
  end

  assign in_rdy    = in_rdy_q;
  assign dout      = dout_q;
  assign out_vld   = out_vld_q;
  assign err_len   = err_len_q;
  assign dbg_state = state_q;

endmodule
